sr04_responder: RTL

- Synthesizable model of the HC-SR04 side of the ultrasonic link: receives Trigger from the pet's ultrasonic measuring block and answers with an Echo pulse whose width encodes a programmed distance.
- Sits on a second FPGA or in the bench in place of the physical sensor.
- Lets the "Carino" (petting) path be exercised deterministically with repeatable distances, missing objects and malformed triggers.

---
 rtl/sr04_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sr04_responder.sv
// HC-SR04 sensor emulator: answers a qualified Trigger pulse with an Echo pulse
// whose width encodes a programmed distance, followed by a holdoff dead time.
`timescale 1ns/1ps

module sr04_responder #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Trigger,
    input  logic [8:0] distance_cm,
    input  logic       obj_present,
    output logic       Echo,
    output logic       busy,
    output logic       short_trig,
    output logic [7:0] meas_count
);

    localparam int CYC_US      = CLK_HZ / 1_000_000;
    localparam int TRIG_CYC    = TRIG_MIN_US * CYC_US;
    localparam int BURST_CYC   = BURST_US * CYC_US;
    localparam int CM_CYC      = US_PER_CM * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
    localparam int HOLD_CYC    = HOLDOFF_US * CYC_US;
    localparam int RANGE_CYC   = MAX_CM * CM_CYC;
    localparam int ECHO_MAX    = (TIMEOUT_CYC > RANGE_CYC) ? TIMEOUT_CYC : RANGE_CYC;
    localparam int TMAX_A      = (ECHO_MAX > HOLD_CYC) ? ECHO_MAX : HOLD_CYC;
    localparam int TIMER_MAX   = (TMAX_A > BURST_CYC) ? TMAX_A : BURST_CYC;
    localparam int TW          = $clog2(TIMER_MAX + 1);
    localparam int CW          = $clog2(TRIG_CYC + 1);

    localparam logic [CW-1:0] TRIG_SAT    = CW'(TRIG_CYC);
    localparam logic [CW-1:0] TRIG_ACCEPT = CW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] BURST_LAST  = TW'(BURST_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LEN = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] CM_LEN      = TW'(CM_CYC);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [8:0]    MAX_D       = 9'(MAX_CM);
    localparam logic [8:0]    MIN_D       = 9'(MIN_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t        state, state_next;
    logic          trig_meta, trig_s, trig_d;
    logic          trig_rise, trig_fall;
    logic [CW-1:0] trig_cnt, trig_cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic [TW-1:0] echo_len, echo_len_next;
    logic [TW-1:0] latched_len;
    logic [8:0]    dist_clamped;
    logic          echo_next, busy_next, short_next;
    logic [7:0]    count_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            trig_meta <= Trigger;
            trig_s    <= trig_meta;
            trig_d    <= trig_s;
        end
    end

    assign trig_rise    = trig_s & ~trig_d;
    assign trig_fall    = ~trig_s & trig_d;
    assign dist_clamped = (distance_cm < MIN_D) ? MIN_D : distance_cm;

    // Echo length is resolved to a cycle count once, at the moment of acceptance.
    always_comb begin
        latched_len = TW'(dist_clamped) * CM_LEN;
        if (!obj_present || (distance_cm > MAX_D)) begin
            latched_len = TIMEOUT_LEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            trig_cnt   <= '0;
            timer      <= '0;
            echo_len   <= '0;
            Echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
            meas_count <= '0;
        end else begin
            state      <= state_next;
            trig_cnt   <= trig_cnt_next;
            timer      <= timer_next;
            echo_len   <= echo_len_next;
            Echo       <= echo_next;
            busy       <= busy_next;
            short_trig <= short_next;
            meas_count <= count_next;
        end
    end

    // The rise cycle itself is a high cycle, so a count of TRIG_CYC-1 at the
    // fall means the trigger was high for the full minimum time.
    always_comb begin
        state_next    = state;
        trig_cnt_next = trig_cnt;
        timer_next    = timer;
        echo_len_next = echo_len;
        echo_next     = Echo;
        busy_next     = busy;
        short_next    = 1'b0;
        count_next    = meas_count;

        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_next    = TRIG_HI;
                    trig_cnt_next = '0;
                end
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    if (trig_cnt >= TRIG_ACCEPT) begin
                        echo_len_next = latched_len;
                        count_next    = meas_count + 8'd1;
                        busy_next     = 1'b1;
                        timer_next    = '0;
                        state_next    = BURST;
                    end else begin
                        short_next = 1'b1;
                        state_next = IDLE;
                    end
                end else if (trig_s && (trig_cnt != TRIG_SAT)) begin
                    trig_cnt_next = trig_cnt + CW'(1);
                end
            end
            BURST: begin
                if (timer == BURST_LAST) begin
                    timer_next = '0;
                    echo_next  = 1'b1;
                    state_next = ECHO;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            ECHO: begin
                if (timer == (echo_len - TIMER_ONE)) begin
                    timer_next = '0;
                    echo_next  = 1'b0;
                    state_next = HOLDOFF;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            HOLDOFF: begin
                if (timer == HOLD_LAST) begin
                    timer_next = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
